// File: rtl/mem2_port_arbiter.sv
// Arbiter for OTTER memory port 2: CPU (A) has fixed priority over the debug/loader port (B),
// with an anti-starvation counter for B, a B burst lock, and read-data tagging for the one-cycle read latency.
module mem2_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              a_rden,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_din,
  input  logic [1:0]        a_size,
  input  logic              a_sign,
  output logic              a_gnt,
  output logic              a_valid,
  input  logic              b_rden,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_din,
  input  logic [1:0]        b_size,
  input  logic              b_sign,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic              b_valid,
  output logic [DATA_W-1:0] rd_dout,
  output logic              mem_rden2,
  output logic              mem_we2,
  output logic [ADDR_W-1:0] mem_addr2,
  output logic [DATA_W-1:0] mem_din2,
  output logic [1:0]        mem_size,
  output logic              mem_sign,
  input  logic [DATA_W-1:0] mem_dout2
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic       req_a, req_b;
  logic       gnt_a, gnt_b;
  logic       rd_pend_q, rd_pend_d;
  logic       rd_owner_q, rd_owner_d;
  logic       lock_q, lock_d;
  logic [3:0] starve_q, starve_d;

  assign req_a = a_rden | a_we;
  assign req_b = b_rden | b_we;

  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (!RST) begin
      if (lock_q) begin
        gnt_b = req_b;
      end else if (req_b && (starve_q == STARVE_LIM)) begin
        gnt_b = 1'b1;
      end else if (req_a) begin
        gnt_a = 1'b1;
      end else if (req_b) begin
        gnt_b = 1'b1;
      end
    end
  end

  // A write wins over a simultaneous read from the same requester.
  always_comb begin
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    mem_addr2 = '0;
    mem_din2  = '0;
    mem_size  = '0;
    mem_sign  = 1'b0;
    if (gnt_a) begin
      mem_rden2 = a_rden & ~a_we;
      mem_we2   = a_we;
      mem_addr2 = a_addr;
      mem_din2  = a_din;
      mem_size  = a_size;
      mem_sign  = a_sign;
    end else if (gnt_b) begin
      mem_rden2 = b_rden & ~b_we;
      mem_we2   = b_we;
      mem_addr2 = b_addr;
      mem_din2  = b_din;
      mem_size  = b_size;
      mem_sign  = b_sign;
    end
  end

  assign a_gnt   = gnt_a;
  assign b_gnt   = gnt_b;
  assign a_valid = ~RST & rd_pend_q & ~rd_owner_q;
  assign b_valid = ~RST & rd_pend_q & rd_owner_q;
  assign rd_dout = (a_valid | b_valid) ? mem_dout2 : '0;

  always_comb begin
    rd_pend_d  = mem_rden2;
    rd_owner_d = gnt_b;
    starve_d   = starve_q;
    lock_d     = lock_q;
    if (gnt_b || !req_b) begin
      starve_d = '0;
    end else if (gnt_a && (starve_q < STARVE_LIM)) begin
      starve_d = starve_q + 4'd1;
    end
    // b_lock low on any edge releases the port, whether or not B is requesting.
    if (!b_lock) begin
      lock_d = 1'b0;
    end else if (gnt_b) begin
      lock_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
      starve_q   <= '0;
      lock_q     <= 1'b0;
    end else begin
      rd_pend_q  <= rd_pend_d;
      rd_owner_q <= rd_owner_d;
      starve_q   <= starve_d;
      lock_q     <= lock_d;
    end
  end

endmodule

// File: tb/tb_mem2_port_arbiter.sv
// Bench for mem2_port_arbiter: directed scenarios plus random traffic, all checked against
// a behavioural model of the arbitration rules with its own shadow memory.
module tb_mem2_port_arbiter;
  localparam int SMAX = 4;

  logic        clk = 1'b0;
  logic        RST;
  logic        a_rden, a_we, a_sign, b_rden, b_we, b_sign, b_lock;
  logic [31:0] a_addr, a_din, b_addr, b_din;
  logic [1:0]  a_size, b_size;
  logic        a_gnt, a_valid, b_gnt, b_valid;
  logic [31:0] rd_dout, mem_addr2, mem_din2, mem_dout2;
  logic        mem_rden2, mem_we2, mem_sign;
  logic [1:0]  mem_size;

  always #5 clk = ~clk;

  mem2_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .RST(RST),
    .a_rden(a_rden), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_size(a_size), .a_sign(a_sign),
    .a_gnt(a_gnt), .a_valid(a_valid),
    .b_rden(b_rden), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_size(b_size), .b_sign(b_sign),
    .b_lock(b_lock), .b_gnt(b_gnt), .b_valid(b_valid),
    .rd_dout(rd_dout), .mem_rden2(mem_rden2), .mem_we2(mem_we2), .mem_addr2(mem_addr2),
    .mem_din2(mem_din2), .mem_size(mem_size), .mem_sign(mem_sign), .mem_dout2(mem_dout2)
  );

  int total = 0;
  int bad   = 0;

  // Synchronous memory: garbage on mem_dout2 whenever no read was issued.
  logic [31:0] mem_arr [256];
  always @(posedge clk) begin
    if (mem_we2) mem_arr[mem_addr2[9:2]] <= mem_din2;
    mem_dout2 <= mem_rden2 ? mem_arr[mem_addr2[9:2]] : $urandom;
  end

  logic [31:0] shadow [256];
  int          m_starve;
  bit          m_lock, m_pend, m_owner;
  logic [31:0] m_data;

  logic        e_ga, e_gb, e_rd, e_we;
  logic [31:0] e_addr, e_din;
  logic [5:0]  e_ctl;
  logic [66:0] e_bus;
  logic [31:0] e_dout;

  wire [5:0]  ctl = {a_gnt, b_gnt, a_valid, b_valid, mem_rden2, mem_we2};
  wire [66:0] bus = {mem_addr2, mem_din2, mem_size, mem_sign};

  task automatic model_eval();
    logic ra, rb, av, bv;
    ra = a_rden | a_we;
    rb = b_rden | b_we;
    e_ga = 1'b0; e_gb = 1'b0;
    if (!RST) begin
      if (m_lock) e_gb = rb;
      else if (rb && m_starve == SMAX) e_gb = 1'b1;
      else if (ra) e_ga = 1'b1;
      else if (rb) e_gb = 1'b1;
    end
    e_rd = 1'b0; e_we = 1'b0; e_addr = '0; e_din = '0; e_bus = '0;
    if (e_ga) begin
      e_we = a_we; e_rd = a_rden & ~a_we; e_addr = a_addr; e_din = a_din;
      e_bus = {a_addr, a_din, a_size, a_sign};
    end else if (e_gb) begin
      e_we = b_we; e_rd = b_rden & ~b_we; e_addr = b_addr; e_din = b_din;
      e_bus = {b_addr, b_din, b_size, b_sign};
    end
    av = !RST && m_pend && !m_owner;
    bv = !RST && m_pend && m_owner;
    e_ctl  = {e_ga, e_gb, av, bv, e_rd, e_we};
    e_dout = (av || bv) ? m_data : 32'h0;
  endtask

  task automatic model_commit();
    if (RST) begin
      m_starve = 0; m_lock = 0; m_pend = 0; m_owner = 0;
    end else begin
      m_pend  = e_rd;
      m_owner = e_gb;
      if (e_rd) m_data = shadow[e_addr[9:2]];
      if (e_we) shadow[e_addr[9:2]] = e_din;
      if (e_gb || !(b_rden | b_we)) m_starve = 0;
      else if (e_ga && m_starve < SMAX) m_starve++;
      if (!b_lock) m_lock = 0;
      else if (e_gb) m_lock = 1;
    end
  endtask

  task automatic tick();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    a_rden = 0; a_we = 0; a_addr = '0; a_din = '0; a_size = '0; a_sign = 0;
    b_rden = 0; b_we = 0; b_addr = '0; b_din = '0; b_size = '0; b_sign = 0; b_lock = 0;
  endtask

  task automatic do_reset();
    RST = 1; set_idle(); #4; tick(); RST = 0;
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    mem_arr[idx] = val;
    shadow[idx]  = val;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      RST = (i < 2); a_rden = 1; a_addr = 32'h20; b_we = 1; b_addr = 32'h24; b_din = 32'h1234;
      #4; model_eval();
      total++; if (ctl !== e_ctl) begin bad++; $display("FAIL reset ctl cyc=%0d got=%b exp=%b", i, ctl, e_ctl); end
      total++; if (bus !== e_bus) begin bad++; $display("FAIL reset bus cyc=%0d got=%h exp=%h", i, bus, e_bus); end
      total++; if (rd_dout !== e_dout) begin bad++; $display("FAIL reset dout cyc=%0d got=%h exp=%h", i, rd_dout, e_dout); end
      if (i < 2) begin
        total++; if (ctl !== 6'b0 || rd_dout !== 32'h0) begin bad++; $display("FAIL reset_quiet cyc=%0d ctl=%b dout=%h exp=0", i, ctl, rd_dout); end
      end else begin
        total++; if ({a_gnt, b_gnt} !== 2'b10) begin bad++; $display("FAIL reset_first_gnt got=%b exp=10", {a_gnt, b_gnt}); end
      end
      tick();
    end
    set_idle();
  endtask

  task automatic test_cpu_read();
    do_reset();
    preload(32'h100 >> 2, 32'hDEADBEEF);
    for (int i = 0; i < 2; i++) begin
      set_idle();
      if (i == 0) begin a_rden = 1; a_addr = 32'h100; end
      #4; model_eval();
      total++; if (ctl !== e_ctl) begin bad++; $display("FAIL cpu_read ctl cyc=%0d got=%b exp=%b", i, ctl, e_ctl); end
      total++; if (bus !== e_bus) begin bad++; $display("FAIL cpu_read bus cyc=%0d got=%h exp=%h", i, bus, e_bus); end
      total++; if (rd_dout !== e_dout) begin bad++; $display("FAIL cpu_read dout cyc=%0d got=%h exp=%h", i, rd_dout, e_dout); end
      if (i == 0) begin
        total++; if (ctl !== 6'b100010 || mem_addr2 !== 32'h100) begin bad++; $display("FAIL cpu_read_issue ctl=%b addr=%h exp=100010/100", ctl, mem_addr2); end
      end else begin
        total++; if (ctl !== 6'b001000 || rd_dout !== 32'hDEADBEEF) begin bad++; $display("FAIL cpu_read_data ctl=%b dout=%h exp=001000/deadbeef", ctl, rd_dout); end
      end
      tick();
    end
  endtask

  task automatic test_contention();
    logic [1:0] want;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      a_rden = 1; a_addr = 32'({$urandom_range(0, 255), 2'b00});
      b_rden = 1; b_addr = 32'({$urandom_range(0, 255), 2'b00});
      #4; model_eval();
      total++; if (ctl !== e_ctl) begin bad++; $display("FAIL contention ctl cyc=%0d got=%b exp=%b", i, ctl, e_ctl); end
      total++; if (bus !== e_bus) begin bad++; $display("FAIL contention bus cyc=%0d got=%h exp=%h", i, bus, e_bus); end
      total++; if (rd_dout !== e_dout) begin bad++; $display("FAIL contention dout cyc=%0d got=%h exp=%h", i, rd_dout, e_dout); end
      want = (i % 5 == 4) ? 2'b01 : 2'b10;
      total++; if ({a_gnt, b_gnt} !== want) begin bad++; $display("FAIL contention_pattern cyc=%0d got=%b exp=%b", i, {a_gnt, b_gnt}, want); end
      tick();
    end
    set_idle();
  endtask

  task automatic test_lock();
    logic [1:0] want;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_idle();
      a_rden = (i > 0); a_addr = 32'h40;
      b_lock = (i < 5);
      if (i < 3) begin b_we = 1; b_addr = 32'h10 + 32'(i * 4); b_din = $urandom; end
      #4; model_eval();
      total++; if (ctl !== e_ctl) begin bad++; $display("FAIL lock ctl cyc=%0d got=%b exp=%b", i, ctl, e_ctl); end
      total++; if (bus !== e_bus) begin bad++; $display("FAIL lock bus cyc=%0d got=%h exp=%h", i, bus, e_bus); end
      want = (i < 3) ? 2'b01 : (i == 6) ? 2'b10 : 2'b00;
      total++; if ({a_gnt, b_gnt} !== want) begin bad++; $display("FAIL lock_pattern cyc=%0d got=%b exp=%b", i, {a_gnt, b_gnt}, want); end
      tick();
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    preload(0, 32'hA5A51111);
    preload(1, 32'h5A5A2222);
    for (int i = 0; i < 3; i++) begin
      set_idle();
      if (i == 0) begin a_rden = 1; a_addr = 32'h0; end
      if (i == 1) begin b_rden = 1; b_addr = 32'h4; end
      #4; model_eval();
      total++; if (ctl !== e_ctl) begin bad++; $display("FAIL b2b ctl cyc=%0d got=%b exp=%b", i, ctl, e_ctl); end
      total++; if (rd_dout !== e_dout) begin bad++; $display("FAIL b2b dout cyc=%0d got=%h exp=%h", i, rd_dout, e_dout); end
      if (i == 1) begin
        total++; if ({a_valid, b_valid, b_gnt} !== 3'b101 || rd_dout !== 32'hA5A51111) begin bad++; $display("FAIL b2b_a got=%b/%h exp=101/a5a51111", {a_valid, b_valid, b_gnt}, rd_dout); end
      end
      if (i == 2) begin
        total++; if ({a_valid, b_valid} !== 2'b01 || rd_dout !== 32'h5A5A2222) begin bad++; $display("FAIL b2b_b got=%b/%h exp=01/5a5a2222", {a_valid, b_valid}, rd_dout); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_idle();
      RST = (i == 1);
      if (i == 0) begin a_rden = 1; a_addr = 32'h8; end
      #4; model_eval();
      total++; if (ctl !== e_ctl) begin bad++; $display("FAIL rst_mid ctl cyc=%0d got=%b exp=%b", i, ctl, e_ctl); end
      if (i > 0) begin
        total++; if (a_valid !== 1'b0 || rd_dout !== 32'h0) begin bad++; $display("FAIL rst_mid_valid cyc=%0d valid=%b dout=%h exp=0", i, a_valid, rd_dout); end
      end
      tick();
    end
    RST = 0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      RST    = ($urandom_range(0, 63) == 0);
      a_rden = $urandom_range(0, 1) == 1;
      a_we   = $urandom_range(0, 3) == 0;
      a_addr = 32'({$urandom_range(0, 255), 2'b00});
      a_din  = $urandom; a_size = 2'($urandom); a_sign = 1'($urandom);
      b_rden = $urandom_range(0, 1) == 1;
      b_we   = $urandom_range(0, 3) == 0;
      b_addr = 32'({$urandom_range(0, 255), 2'b00});
      b_din  = $urandom; b_size = 2'($urandom); b_sign = 1'($urandom);
      b_lock = $urandom_range(0, 2) == 0;
      #4; model_eval();
      total++; if (ctl !== e_ctl) begin bad++; $display("FAIL random ctl cyc=%0d got=%b exp=%b", i, ctl, e_ctl); end
      total++; if (bus !== e_bus) begin bad++; $display("FAIL random bus cyc=%0d got=%h exp=%h", i, bus, e_bus); end
      total++; if (rd_dout !== e_dout) begin bad++; $display("FAIL random dout cyc=%0d got=%h exp=%h", i, rd_dout, e_dout); end
      tick();
    end
    RST = 0;
    set_idle();
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      mem_arr[k] = 32'(k) * 32'h01010101;
      shadow[k]  = 32'(k) * 32'h01010101;
    end
    m_starve = 0; m_lock = 0; m_pend = 0; m_owner = 0; m_data = '0;
    RST = 1;
    set_idle();
    @(posedge clk);
    #1;
    test_reset();
    test_cpu_read();
    test_contention();
    test_lock();
    test_back_to_back();
    test_reset_mid_read();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem2_port_arbiter.md
Name: mem2_port_arbiter

Overview:
- Shares OTTER memory port 2 (data port) between two requesters.
  - Requester A is the CPU load/store path, driven by the control unit's memRDEN2/memWE2.
  - Requester B is the debug/program-loader port.
- Fixed CPU priority with an anti-starvation counter and a debug lock for multi-word bursts.
- Tracks the one-cycle synchronous read latency so returned data is tagged to the correct requester.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive CPU grants while B is pending before B is forced a grant (range 1..15).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous, active-high reset.
- a_rden  in  1  CPU read request (level).
- a_we  in  1  CPU write request (level).
- a_addr  in  ADDR_W  CPU address.
- a_din  in  DATA_W  CPU write data.
- a_size  in  2  CPU access size.
- a_sign  in  1  CPU unsigned flag.
- a_gnt  out  1  CPU request accepted this cycle.
- a_valid  out  1  CPU read data valid.
- b_rden  in  1  debug read request.
- b_we  in  1  debug write request.
- b_addr  in  ADDR_W  debug address.
- b_din  in  DATA_W  debug write data.
- b_size  in  2  debug access size.
- b_sign  in  1  debug unsigned flag.
- b_lock  in  1  debug holds port across consecutive requests.
- b_gnt  out  1  debug request accepted.
- b_valid  out  1  debug read data valid.
- rd_dout  out  DATA_W  read data to the owning requester (mem_dout2 passthrough).
- mem_rden2  out  1  memory read enable.
- mem_we2  out  1  memory write enable.
- mem_addr2  out  ADDR_W  memory address.
- mem_din2  out  DATA_W  memory write data.
- mem_size  out  2  memory access size.
- mem_sign  out  1  memory unsigned flag.
- mem_dout2  in  DATA_W  memory read data; valid one cycle after mem_rden2.

Behaviour:
- Request:
  - reqA = a_rden|a_we; reqB = b_rden|b_we.
  - rden and we from the same requester asserted together is illegal; rden is ignored and a write is performed.
- Grant is combinational, same cycle. At most one of a_gnt/b_gnt is high.
- Owner selection, first match wins:
  - (1) RST=1 → no grant.
  - (2) lock_held=1 → B if reqB, else none (port idles).
  - (3) reqB and starve_cnt==STARVE_MAX → B.
  - (4) reqA → A.
  - (5) reqB → B.
  - (6) none.
- Memory side:
  - mem_* mirror the granted requester's addr/din/size/sign/rden/we.
  - With no grant: mem_rden2=0, mem_we2=0, addr/din/size/sign=0.
- Writes complete in the grant cycle. No response beyond gnt.
- Read return:
  - Registered rd_pend, rd_owner are captured on a granted read.
  - Next cycle: a_valid = rd_pend & ~rd_owner, or b_valid = rd_pend & rd_owner; rd_dout = mem_dout2.
  - A new grant may issue in the same cycle as a valid (fully pipelined, one access per cycle).
  - rd_dout is 0 when neither valid is asserted.
- starve_cnt (4-bit register):
  - +1 on each A grant while reqB=1.
  - Cleared on any B grant, or when reqB=0.
  - Saturates at STARVE_MAX.
- lock_held (register):
  - Set on a B grant with b_lock=1.
  - Cleared when b_lock=0 is sampled on any edge.
  - While held, A is stalled (a_gnt=0) even if B is idle.
- Requesters hold level requests until they see gnt. Deasserting a request without a grant is legal, with no side effects.
- Reset: RST=1 clears rd_pend, rd_owner, starve_cnt, lock_held. During the RST cycle all outputs are 0: gnt, valid, mem_* strobes, rd_dout.
- Reset mid-operation: a read granted in the cycle before RST produces no valid.
- Latency: gnt in cycle 0, read data with valid in cycle 1.
- Simultaneous reqA/reqB with starve_cnt<STARVE_MAX: A wins.

Test Plan:
- Reset: RST=1 for 2 cycles with a_rden=b_we=1 → all gnt/valid/mem strobes 0; after release a_gnt=1 first cycle, starve_cnt=1.
- CPU read: a_rden=1, a_addr=0x100, mem_dout2=0xDEADBEEF next cycle → a_gnt same cycle, mem_rden2=1 addr 0x100; next cycle a_valid=1, rd_dout=0xDEADBEEF, b_valid=0.
- Contention: reqA and reqB continuously asserted, STARVE_MAX=4 → grant pattern A,A,A,A,B,A,A,A,A,B…
- Debug lock: b_we with b_lock=1 for 3 writes (0x10, 0x14, 0x18) while a_rden held → three b_gnt, a_gnt=0 throughout and during idle gap; a_gnt=1 the cycle after b_lock deasserts.
- Back-to-back mixed reads: A read 0x0 then B read 0x4 in consecutive cycles → a_valid in cycle 1, b_valid in cycle 2, data not swapped.
- Reset mid-read: A read granted, RST asserted next cycle → a_valid=0, rd_dout=0, rd_pend clear after reset.
